array_prod: RTL and testbench
=============================

ARRAY_PROD -- requirements
Module: array_prod

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports are named clock and reset.
REQ-002 Parameter ARRAY_SZ, default 8, SHALL set the number of vector elements (power of two, >= 2).
REQ-003 Parameter QN, default 6, SHALL set the integer bits of the signed fixed-point format.
REQ-004 Parameter QM, default 11, SHALL set the fractional bits.
REQ-005 The block SHALL derive BITWIDTH = QN+QM+1 (18 by default).
REQ-006 The positional port order SHALL be array1, array2, clock, reset, dataReady, outputVal.
REQ-007 clock  input  1  rising-edge clock for all state.
REQ-008 reset  input  1  synchronous, active-high; high means clear and hold idle, low means compute.
REQ-009 array1  input  ARRAY_SZ*BITWIDTH  packed signed vector; element i = bits [i*BITWIDTH +: BITWIDTH].
REQ-010 array2  input  ARRAY_SZ*BITWIDTH  second packed signed vector, same packing.
REQ-011 dataReady  output  1  high when outputVal holds the completed dot product.
REQ-012 outputVal  output  BITWIDTH  signed Q(QN.QM) dot product result.

Function
REQ-013 The block SHALL compute sum over i of array1[i]*array2[i], with all operands two's-complement Q(QN.QM).
REQ-014 It SHALL process one element per clock with a single multiplier; the element index counts 0 to ARRAY_SZ-1.
REQ-015 Each full 2*BITWIDTH product SHALL be added, unrounded, into a signed accumulator of 2*BITWIDTH+log2(ARRAY_SZ) bits; the accumulator never overflows.
REQ-016 The result SHALL be the accumulator arithmetically shifted right by QM bits (truncation toward minus infinity).
REQ-017 The shifted result SHALL saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-018 The state machine SHALL have two states, MAC and DONE.
REQ-019 In MAC the block SHALL accumulate element idx on each rising edge with reset low and increment idx.
REQ-020 After the MAC of element ARRAY_SZ-1, the next edge SHALL register outputVal, set dataReady=1 and enter DONE.
REQ-021 In DONE, outputVal and dataReady SHALL hold until reset; the inputs are ignored.
REQ-022 Latency: on the first edge with reset low, element 0 SHALL be accumulated, and dataReady SHALL rise on the (ARRAY_SZ+1)th edge with reset low (9 for the default).
REQ-023 The inputs SHALL be sampled every cycle; the user keeps array1 and array2 stable from reset deassertion until dataReady.
REQ-024 dataReady SHALL never be high while any MAC is pending.

Reset
REQ-025 On any rising edge with reset high, the block SHALL set state=MAC, idx=0, accumulator=0, dataReady=0 and outputVal=0.
REQ-026 Reset asserted mid-computation or in DONE SHALL abort and clear everything the same way; a new computation starts on the first edge with reset low.
REQ-027 The block SHALL have no asynchronous behaviour; outputs change only on clock edges.

Verification
REQ-028 Identity case (defaults): all array1 and array2 elements = 18'h00800 (1.0) -> outputVal=18'h04000 (8.0), with dataReady rising on the 9th edge after reset deasserts.
REQ-029 Mixed sign: element 3 = 1.5 (3072) x -2.0 (-4096), all other elements 0 -> outputVal=-6144 (18'h3E800).
REQ-030 Saturation: all elements 31.0 (63488) x 31.0 -> outputVal=18'h1FFFF; with array2=-31.0 -> outputVal=18'h20000.
REQ-031 Truncation: element 0 = 1 LSB x 1 LSB, others 0 -> outputVal=0; element 0 = -1 LSB x 1 LSB -> outputVal=18'h3FFFF.
REQ-032 Reset mid-op: assert reset at the 4th compute edge, release it, keep identity inputs -> dataReady=0 immediately, then outputVal=18'h04000 and dataReady=1 on the 9th edge after release.
REQ-033 Random regression: 1000 random vector pairs, each run as reset-release-compute -> outputVal matches the floor/saturate golden model exactly, and dataReady holds in DONE until reset.

Source files
------------

// File: rtl/array_prod.sv
// array_prod: serial fixed-point dot product of two packed signed vectors.
//
// One multiply-accumulate per clock over ARRAY_SZ elements. The full
// 2*BITWIDTH products are summed without rounding into a wide accumulator.
// One extra edge then floors the sum back to Q(QN.QM), saturates it and
// registers it. The result then holds until the next reset.
//
// Ports:
//   array1    in  ARRAY_SZ*BITWIDTH  packed signed vector, element i = [i*BITWIDTH +: BITWIDTH]
//   array2    in  ARRAY_SZ*BITWIDTH  second packed signed vector, same packing
//   clock     in  1                  rising-edge clock for all state
//   reset     in  1                  synchronous active-high clear; low = compute
//   dataReady out 1                  high once outputVal holds the finished result
//   outputVal out BITWIDTH           signed Q(QN.QM) saturated dot product
module array_prod #(
  parameter int ARRAY_SZ = 8,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int BITWIDTH = QN + QM + 1
) (
  input  logic [ARRAY_SZ*BITWIDTH-1:0] array1,
  input  logic [ARRAY_SZ*BITWIDTH-1:0] array2,
  input  logic                         clock,
  input  logic                         reset,
  output logic                         dataReady,
  output logic [BITWIDTH-1:0]          outputVal
);

  localparam int IDXW = $clog2(ARRAY_SZ);
  localparam int PRDW = 2 * BITWIDTH;
  localparam int ACCW = PRDW + IDXW;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    MAC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic [IDXW-1:0]           idx_r;
  logic                      last_r;      // every element has been accumulated
  logic signed [ACCW-1:0]    acc_r;
  logic                      mac_en_s;
  logic                      load_s;
  logic signed [BITWIDTH-1:0] elem1_s;
  logic signed [BITWIDTH-1:0] elem2_s;
  logic signed [PRDW-1:0]    prod_s;
  logic signed [ACCW-1:0]    shifted_s;

  // Clamps a floored accumulator value to the representable output range.
  function automatic logic [BITWIDTH-1:0] saturate(input logic signed [ACCW-1:0] v);
    logic [BITWIDTH-1:0] r;
    if (v > MAX_V) begin
      r = MAX_V[BITWIDTH-1:0];
    end else if (v < MIN_V) begin
      r = MIN_V[BITWIDTH-1:0];
    end else begin
      r = v[BITWIDTH-1:0];
    end
    return r;
  endfunction

  // Element select and the single multiplier.
  always_comb begin
    elem1_s   = array1[idx_r*BITWIDTH +: BITWIDTH];
    elem2_s   = array2[idx_r*BITWIDTH +: BITWIDTH];
    prod_s    = elem1_s * elem2_s;
    shifted_s = acc_r >>> QM;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= MAC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: leave MAC on the finalisation edge, stay in DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MAC: begin
        if (last_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MAC;
        end
      end
      DONE:    state_next_s = DONE;
      default: state_next_s = MAC;
    endcase
  end

  // Datapath controls decoded from the state.
  always_comb begin
    mac_en_s = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      MAC: begin
        if (last_r) begin
          load_s = 1'b1;
        end else begin
          mac_en_s = 1'b1;
        end
      end
      DONE: begin
        mac_en_s = 1'b0;
        load_s   = 1'b0;
      end
      default: begin
        mac_en_s = 1'b0;
        load_s   = 1'b0;
      end
    endcase
  end

  // Accumulator, index and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r     <= '0;
      last_r    <= 1'b0;
      acc_r     <= '0;
      dataReady <= 1'b0;
      outputVal <= '0;
    end else begin
      if (mac_en_s) begin
        acc_r <= acc_r + {{IDXW{prod_s[PRDW-1]}}, prod_s};
        idx_r <= idx_r + IDXW'(1);
        if (idx_r == IDXW'(ARRAY_SZ - 1)) begin
          last_r <= 1'b1;
        end else begin
          last_r <= last_r;
        end
      end else begin
        acc_r <= acc_r;
        idx_r <= idx_r;
      end
      if (load_s) begin
        outputVal <= saturate(shifted_s);
        dataReady <= 1'b1;
      end else begin
        outputVal <= outputVal;
        dataReady <= dataReady;
      end
    end
  end

endmodule

// File: tb/tb_array_prod.sv
module tb_array_prod;

  localparam int SZ = 8;
  localparam int BW = 18;

  logic [SZ*BW-1:0] array1;
  logic [SZ*BW-1:0] array2;
  logic             clock;
  logic             reset;
  logic             dataReady;
  logic [BW-1:0]    outputVal;

  int n_checks = 0;
  int n_fail   = 0;

  array_prod dut (
    .array1    (array1),
    .array2    (array2),
    .clock     (clock),
    .reset     (reset),
    .dataReady (dataReady),
    .outputVal (outputVal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [BW-1:0] v1, input logic [BW-1:0] v2);
    for (int i = 0; i < SZ; i++) begin
      array1[i*BW +: BW] = v1;
      array2[i*BW +: BW] = v2;
    end
  endtask

  // Releases reset and counts edges until dataReady (bounded at 20).
  task automatic run(output int edges);
    reset = 1'b0;
    edges = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (dataReady === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  // Floor/saturate reference computed with 64-bit integers.
  function automatic logic [BW-1:0] golden(input logic [SZ*BW-1:0] a, input logic [SZ*BW-1:0] b);
    longint acc;
    longint sh;
    logic signed [BW-1:0] x;
    logic signed [BW-1:0] y;
    logic [63:0] bits;
    acc = 0;
    for (int i = 0; i < SZ; i++) begin
      x = a[i*BW +: BW];
      y = b[i*BW +: BW];
      acc = acc + longint'(x) * longint'(y);
    end
    sh = acc >>> 11;
    if (sh > 131071) sh = 131071;
    else if (sh < -131072) sh = -131072;
    bits = sh;
    return bits[BW-1:0];
  endfunction

  task automatic test_reset();
    fill(18'h00800, 18'h00800);
    do_reset();
    tick();
    n_checks++;
    if (dataReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", dataReady); end
    n_checks++;
    if (outputVal !== 18'h00000) begin n_fail++; $display("FAIL reset_value got=%h want=00000", outputVal); end
  endtask

  task automatic test_identity();
    int e;
    fill(18'h00800, 18'h00800);
    do_reset();
    run(e);
    n_checks++;
    if (e !== 9) begin n_fail++; $display("FAIL identity_latency got=%0d want=9", e); end
    n_checks++;
    if (outputVal !== 18'h04000) begin n_fail++; $display("FAIL identity_value got=%h want=04000", outputVal); end
  endtask

  task automatic test_done_hold();
    logic [BW-1:0] held;
    held = outputVal;
    fill(18'h01000, 18'h3F000);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (dataReady !== 1'b1) begin n_fail++; $display("FAIL hold_ready got=%b want=1", dataReady); end
    n_checks++;
    if (outputVal !== 18'h04000 || held !== 18'h04000) begin
      n_fail++; $display("FAIL hold_value got=%h want=04000", outputVal);
    end
  endtask

  task automatic test_mixed_sign();
    int e;
    fill(18'h00000, 18'h00000);
    array1[3*BW +: BW] = 18'h00C00;
    array2[3*BW +: BW] = 18'h3F000;
    do_reset();
    run(e);
    n_checks++;
    if (outputVal !== 18'h3E800 || e !== 9) begin
      n_fail++; $display("FAIL mixed_sign got=%h edges=%0d want=3e800 edges=9", outputVal, e);
    end
  endtask

  task automatic test_saturation();
    int e;
    fill(18'h0F800, 18'h0F800);
    do_reset();
    run(e);
    n_checks++;
    if (outputVal !== 18'h1FFFF) begin n_fail++; $display("FAIL sat_pos got=%h want=1ffff", outputVal); end
    fill(18'h0F800, 18'h30800);
    do_reset();
    run(e);
    n_checks++;
    if (outputVal !== 18'h20000) begin n_fail++; $display("FAIL sat_neg got=%h want=20000", outputVal); end
  endtask

  task automatic test_truncation();
    int e;
    fill(18'h00000, 18'h00000);
    array1[0 +: BW] = 18'h00001;
    array2[0 +: BW] = 18'h00001;
    do_reset();
    run(e);
    n_checks++;
    if (outputVal !== 18'h00000 || dataReady !== 1'b1) begin
      n_fail++; $display("FAIL trunc_pos got=%h rdy=%b want=00000 rdy=1", outputVal, dataReady);
    end
    array1[0 +: BW] = 18'h3FFFF;
    do_reset();
    run(e);
    n_checks++;
    if (outputVal !== 18'h3FFFF) begin n_fail++; $display("FAIL trunc_neg got=%h want=3ffff", outputVal); end
  endtask

  task automatic test_reset_mid_op();
    int e;
    fill(18'h00800, 18'h00800);
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (dataReady !== 1'b0 || outputVal !== 18'h00000) begin
      n_fail++; $display("FAIL midop_clear got=%h rdy=%b want=00000 rdy=0", outputVal, dataReady);
    end
    run(e);
    n_checks++;
    if (e !== 9 || outputVal !== 18'h04000) begin
      n_fail++; $display("FAIL midop_rerun got=%h edges=%0d want=04000 edges=9", outputVal, e);
    end
  endtask

  task automatic test_random();
    int e;
    logic [BW-1:0] exp_v;
    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < SZ; i++) begin
        case (r % 3)
          0:       begin array1[i*BW +: BW] = BW'($urandom); array2[i*BW +: BW] = BW'($urandom); end
          1:       begin array1[i*BW +: BW] = BW'($urandom_range(0, 4095) - 2048);
                         array2[i*BW +: BW] = BW'($urandom_range(0, 4095) - 2048); end
          default: begin array1[i*BW +: BW] = BW'($urandom_range(0, 255) - 128);
                         array2[i*BW +: BW] = BW'($urandom); end
        endcase
      end
      exp_v = golden(array1, array2);
      do_reset();
      run(e);
      n_checks++;
      if (e !== 9) begin n_fail++; $display("FAIL rand_latency run=%0d got=%0d want=9", r, e); end
      n_checks++;
      if (outputVal !== exp_v) begin n_fail++; $display("FAIL rand_value run=%0d got=%h want=%h", r, outputVal, exp_v); end
      array1 = ~array1;
      tick();
      tick();
      n_checks++;
      if (dataReady !== 1'b1 || outputVal !== exp_v) begin
        n_fail++; $display("FAIL rand_hold run=%0d got=%h rdy=%b want=%h rdy=1", r, outputVal, dataReady, exp_v);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    array1 = '0;
    array2 = '0;
    tick();
    test_reset();
    test_identity();
    test_done_hold();
    test_mixed_sign();
    test_saturation();
    test_truncation();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
